// File: rtl/fp_div_seq.sv
// Iterative IEEE-754-style divider: one restoring-division quotient bit per clock, FTZ inputs,
// special-value handling and exception flags. Define FP_DIV_RNE_EN for round-to-nearest-even, else truncation.
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int QW = MAN_W + 4;            // quotient bits produced
  localparam int RW = MAN_W + 2;            // remainder width
  localparam int XW = EXP_W + 2;            // signed working exponent
  localparam int CW = $clog2(QW);
`ifdef FP_DIV_RNE_EN
  localparam int QK = QW;                   // keep guard/round/sticky bits
`else
  localparam int QK = MAN_W + 2;            // only hidden bit, fraction and one spare for normalisation
`endif
  localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} state_t;

  state_t                 state;
  logic [EXP_W+MAN_W:0]   a_q, b_q;
  logic                   sign_q;
  logic signed [XW-1:0]   exp_q;
  logic [RW-1:0]          rem_q;
  logic [MAN_W:0]         div_q;
  logic [QK-1:0]          quo_q;
  logic [CW-1:0]          cnt_q;
  logic                   fin_q;
  logic [MAN_W-1:0]       frac_q;
  logic                   inv_q, dz_q, inf_q, zero_q;

  // Operand classification (zero includes flushed denormals)
  logic [EXP_W-1:0]       ea, eb;
  logic [MAN_W-1:0]       fa, fb;
  logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic signed [XW-1:0]   exp_ab;

  assign ea     = a_q[EXP_W+MAN_W-1:MAN_W];
  assign eb     = b_q[EXP_W+MAN_W-1:MAN_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);
  assign exp_ab = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;

  // One restoring step
  logic          ge;
  logic [RW-1:0] rem_sub;

  assign ge      = rem_q >= {1'b0, div_q};
  assign rem_sub = ge ? rem_q - {1'b0, div_q} : rem_q;

  // Normalisation and rounding
  logic [MAN_W-1:0]     frac_r;
  logic signed [XW-1:0] exp_n, exp_r;

  assign exp_n = quo_q[QK-1] ? exp_q : exp_q - XW'(1);

`ifdef FP_DIV_RNE_EN
  logic [QW-1:0]    qn;
  logic             inc;
  logic [MAN_W+1:0] mant;

  always_comb begin
    qn     = quo_q[QK-1] ? quo_q : {quo_q[QK-2:0], 1'b0};
    inc    = qn[2] & (qn[1] | qn[0] | (|rem_q) | qn[3]);
    mant   = {1'b0, qn[QW-1:3]} + (MAN_W+2)'(inc);
    // A carry out means the mantissa rolled over to 10.00..0: fraction is zero, exponent bumps
    frac_r = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];
    exp_r  = exp_n + XW'(mant[MAN_W+1]);
  end
`else
  always_comb begin
    frac_r = quo_q[QK-1] ? quo_q[QK-2:1] : quo_q[QK-3:0];
    exp_r  = exp_n;
  end
`endif

  // NOTE: only control and architecturally visible outputs are reset; the datapath registers
  // are always written before they are read, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flags  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            cnt_q <= '0;
            flags <= '0;
            busy  <= 1'b1;
            state <= UNPACK;
          end else begin
            state <= IDLE;
          end
        end
        UNPACK: begin
          sign_q <= a_q[EXP_W+MAN_W] ^ b_q[EXP_W+MAN_W];
          exp_q  <= exp_ab;
          rem_q  <= {2'b01, fa};
          div_q  <= {1'b1, fb};
          quo_q  <= '0;
          inv_q  <= a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
          dz_q   <= b_zero & ~a_zero & ~a_inf;
          inf_q  <= a_inf;
          zero_q <= a_zero | b_inf;
          state  <= DIVIDE;
        end
        DIVIDE: begin
          rem_q <= rem_sub << 1;
          if (cnt_q < CW'(QK)) quo_q <= {quo_q[QK-2:0], ge};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(QW - 1)) begin
            fin_q <= 1'b0;
            state <= ROUND;
          end
        end
        ROUND: begin
          if (!fin_q) begin
            frac_q <= frac_r;
            exp_q  <= exp_r;
            fin_q  <= 1'b1;
          end else begin
            if (inv_q) begin
              result <= {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
              flags  <= 4'b1000;
            end else if (dz_q) begin
              result <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
              flags  <= 4'b0100;
            end else if (inf_q) begin
              result <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (zero_q) begin
              result <= {sign_q, {(EXP_W+MAN_W){1'b0}}};
            end else if (exp_q >= EMAX) begin
              result <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
              flags  <= 4'b0010;
            end else if (exp_q[XW-1] || exp_q == '0) begin
              result <= {sign_q, {(EXP_W+MAN_W){1'b0}}};
              flags  <= 4'b0001;
            end else begin
              result <= {sign_q, exp_q[EXP_W-1:0], frac_q};
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
